load_store_unit: RTL

//  Initiator side of the data-memory port. Accepts one load/store request at a time

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_if.sv | 39 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Access size encodings and FSM state encoding.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus of the load/store unit.
// Suffixes are from the LSU's point of view.
interface lsu_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i,
        input  req_signed_i, req_addr_i, req_wdata_i,
        input  mem_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o,
        output resp_err_o, mem_addr_o, mem_data_o,
        output mem_read_o, mem_write_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i,
        output req_signed_i, req_addr_i, req_wdata_i,
        output mem_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o,
        input  resp_err_o, mem_addr_o, mem_data_o,
        input  mem_read_o, mem_write_o
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: load extract/extend and sub-word store merge.
// Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    input  logic [31:0] buf_word,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rword[8*lane +: 8];
        half_v     = rword[16*lane[1] +: 16];
        load_data  = rword;
        store_data = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data  = {{24{sign_ext & byte_v[7]}}, byte_v};
                store_data = buf_word;
                store_data[8*lane +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data  = {{16{sign_ext & half_v[15]}}, half_v};
                store_data = buf_word;
                store_data[16*lane[1] +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word stores as
// read-modify-write, misaligned/out-of-range accesses rejected.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic  clk_i,
    input  logic  rst_i,
    lsu_if.slave  bus
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    lsu_state_e  state_q, state_d;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, buf_q, rdata_q;
    logic [31:0] ld_data, st_data;
    logic        accept, acc_err;
    logic [31:0] acc_waddr;

    assign accept    = (state_q == S_IDLE) && bus.req_valid_i;
    assign acc_waddr = {bus.req_addr_i[31:2], 2'b00};

    always_comb begin
        acc_err = 1'b0;
        if (bus.req_size_i == SIZE_ILL)
            acc_err = 1'b1;
        if (bus.req_size_i == SIZE_HALF && bus.req_addr_i[0])
            acc_err = 1'b1;
        if (bus.req_size_i == SIZE_WORD && bus.req_addr_i[1:0] != 2'b00)
            acc_err = 1'b1;
        if (acc_waddr > MAX_ADDR)
            acc_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    if (acc_err)
                        state_d = S_RESP;
                    else if (bus.req_we_i && bus.req_size_i == SIZE_WORD)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:   state_d = we_q ? S_WR : S_RESP;
            S_WR:   state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .size       (size_q),
        .sign_ext   (sgn_q),
        .lane       (addr_q[1:0]),
        .rword      (bus.mem_data_i),
        .wdata      (wdata_q),
        .buf_word   (buf_q),
        .load_data  (ld_data),
        .store_data (st_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                sgn_q   <= bus.req_signed_i;
                err_q   <= acc_err;
                size_q  <= bus.req_size_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                rdata_q <= '0;
            end
            if (state_q == S_RD) begin
                buf_q <= bus.mem_data_i;
                if (!we_q)
                    rdata_q <= ld_data;
            end
        end
    end

    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.resp_valid_o = (state_q == S_RESP);
    assign bus.resp_err_o   = (state_q == S_RESP) && err_q;
    assign bus.resp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
    assign bus.mem_addr_o   = {addr_q[31:2], 2'b00};
    assign bus.mem_read_o   = (state_q == S_RD);
    assign bus.mem_write_o  = (state_q == S_WR);
    assign bus.mem_data_o   = (state_q == S_WR) ? st_data : '0;

endmodule
